// File: rtl/vga_terminal_pkg.sv
// Shared VGA 640x480@60 timing, terminal geometry and the glyph table behind font_rom.
// Glyph rows are a pure function of {code, row}, so the ROM synthesises to constant logic.
package vga_terminal_pkg;

  localparam int H_VISIBLE    = 640;
  localparam int H_FRONT      = 16;
  localparam int H_SYNC       = 96;
  localparam int H_BACK       = 48;
  localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam int V_VISIBLE    = 480;
  localparam int V_FRONT      = 10;
  localparam int V_SYNC       = 2;
  localparam int V_BACK       = 33;
  localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int TERM_COLS  = 80;
  localparam int TERM_ROWS  = 30;
  localparam int TERM_CELLS = TERM_COLS * TERM_ROWS;
  localparam int GLYPH_W    = 8;
  localparam int GLYPH_H    = 16;

  typedef struct packed {
    logic [2:0] col;
    logic [3:0] row;
    logic       vis;
    logic       hs_n;
    logic       vs_n;
  } s1_t;

  typedef struct packed {
    logic [2:0] col;
    logic       blank;
    logic       vis;
    logic       hs_n;
    logic       vs_n;
  } s2_t;

  // Drawn glyphs for '0', '1', 'A'; other printable codes get an outline box so
  // stray data is visible. Controls, space and DEL stay blank.
  function automatic logic [7:0] glyph_row(input logic [6:0] code, input logic [3:0] row);
    logic [7:0] bits;
    bits = 8'h00;
    case (code)
      7'h30: begin
        case (row)
          4'd2, 4'd11:               bits = 8'h7C;
          4'd3, 4'd4, 4'd9, 4'd10:   bits = 8'hC6;
          4'd5:                      bits = 8'hCE;
          4'd6:                      bits = 8'hDE;
          4'd7:                      bits = 8'hF6;
          4'd8:                      bits = 8'hE6;
          default:                   bits = 8'h00;
        endcase
      end
      7'h31: begin
        case (row)
          4'd2:                      bits = 8'h18;
          4'd3:                      bits = 8'h38;
          4'd4:                      bits = 8'h78;
          4'd11:                     bits = 8'h7E;
          4'd5, 4'd6, 4'd7, 4'd8,
          4'd9, 4'd10:               bits = 8'h18;
          default:                   bits = 8'h00;
        endcase
      end
      7'h41: begin
        case (row)
          4'd2:                      bits = 8'h10;
          4'd3:                      bits = 8'h38;
          4'd4:                      bits = 8'h6C;
          4'd7:                      bits = 8'hFE;
          4'd5, 4'd6, 4'd8, 4'd9,
          4'd10, 4'd11:              bits = 8'hC6;
          default:                   bits = 8'h00;
        endcase
      end
      default: begin
        if (code > 7'h20 && code < 7'h7F) begin
          if (row == 4'd2 || row == 4'd13) bits = 8'h7E;
          else if (row > 4'd2 && row < 4'd13) bits = 8'h42;
        end
      end
    endcase
    return bits;
  endfunction

endpackage

// File: rtl/vga_terminal_font_rom.sv
// 2048x8 glyph ROM addressed by {code[6:0], row[3:0]}; one-clock read latency.
// Read register updates only when rd_en is high and holds otherwise.
module font_rom
  import vga_terminal_pkg::*;
(
  input  logic        clock,
  input  logic        rd_en,
  input  logic [10:0] addr,
  output logic [7:0]  data
);

  logic [7:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (rd_en) data_d = glyph_row(addr[10:4], addr[3:0]);
  end

  always_ff @(posedge clock) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/vga_terminal.sv
// 80x30 text buffer rendered as 640x480@60 VGA; colour and syncs leave through 3 pix_ce stages.
// Write port never stalls: one write per clock, addresses 2400 and above are dropped.
module vga_terminal
  import vga_terminal_pkg::*;
#(
  parameter int          PIXEL_DIV = 4,
  parameter logic [11:0] FG_COLOR  = 12'hFFF,
  parameter logic [11:0] BG_COLOR  = 12'h000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] terminal_addr,
  input  logic        terminal_write,
  input  logic [7:0]  terminal_data,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic [3:0]  vga_red,
  output logic [3:0]  vga_green,
  output logic [3:0]  vga_blue
);

  localparam int DIV_W = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;
  localparam s1_t S1_RST = '{col: 3'd0, row: 4'd0, vis: 1'b0, hs_n: 1'b1, vs_n: 1'b1};
  localparam s2_t S2_RST = '{col: 3'd0, blank: 1'b0, vis: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

  logic [DIV_W-1:0] div_d, div_q;
  logic [9:0]       h_d, h_q, v_d, v_q;
  s1_t              s1_d, s1_q;
  s2_t              s2_d, s2_q;
  logic             hsync_d, hsync_q, vsync_d, vsync_q;
  logic [11:0]      rgb_d, rgb_q;
  logic             pix_ce, pix_on;
  logic [11:0]      rd_addr;
  logic [7:0]       char_q;
  logic [7:0]       glyph;

  logic [7:0] char_mem [TERM_CELLS];

  assign pix_ce  = (div_q == DIV_W'(PIXEL_DIV - 1));
  assign rd_addr = 12'(v_q[9:4]) * 12'(TERM_COLS) + 12'(h_q[9:3]);

  // Read-first: a same-edge write to the scanned cell shows the old byte this pass.
  always_ff @(posedge clock) begin
    if (terminal_write && terminal_addr < 12'(TERM_CELLS))
      char_mem[terminal_addr] <= terminal_data;
    if (pix_ce)
      char_q <= char_mem[rd_addr];
  end

  font_rom u_font_rom (
    .clock (clock),
    .rd_en (pix_ce),
    .addr  ({char_q[6:0], s1_q.row}),
    .data  (glyph)
  );

  assign pix_on = glyph[3'd7 - s2_q.col] && !s2_q.blank;

  always_comb begin
    div_d   = pix_ce ? '0 : div_q + DIV_W'(1);
    h_d     = h_q;
    v_d     = v_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    rgb_d   = rgb_q;
    if (pix_ce) begin
      if (h_q == 10'(H_TOTAL - 1)) begin
        h_d = '0;
        v_d = (v_q == 10'(V_TOTAL - 1)) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end

      s1_d.col  = h_q[2:0];
      s1_d.row  = v_q[3:0];
      s1_d.vis  = (h_q < 10'(H_VISIBLE)) && (v_q < 10'(V_VISIBLE));
      s1_d.hs_n = !((h_q >= 10'(H_SYNC_START)) && (h_q < 10'(H_SYNC_END)));
      s1_d.vs_n = !((v_q >= 10'(V_SYNC_START)) && (v_q < 10'(V_SYNC_END)));

      // Codes with bit 7 set would alias onto 0x00..0x7F glyphs, so they are forced blank.
      s2_d.col   = s1_q.col;
      s2_d.blank = char_q[7];
      s2_d.vis   = s1_q.vis;
      s2_d.hs_n  = s1_q.hs_n;
      s2_d.vs_n  = s1_q.vs_n;

      hsync_d = s2_q.hs_n;
      vsync_d = s2_q.vs_n;
      rgb_d   = s2_q.vis ? (pix_on ? FG_COLOR : BG_COLOR) : 12'h000;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      s1_q    <= S1_RST;
      s2_q    <= S2_RST;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= 12'h000;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  assign vga_hsync = hsync_q;
  assign vga_vsync = vsync_q;
  assign vga_red   = rgb_q[11:8];
  assign vga_green = rgb_q[7:4];
  assign vga_blue  = rgb_q[3:0];

endmodule

// File: tb/tb_vga_terminal.sv
// Directed bench for vga_terminal: per-pixel scoreboard of sync and colour, plus hsync edge timing.
module tb_vga_terminal;

  localparam int          PD   = 2;
  localparam logic [11:0] FG   = 12'hFA5;
  localparam logic [11:0] BG   = 12'h123;
  localparam logic [13:0] IDLE = {1'b1, 1'b1, 12'h000};

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] terminal_addr = '0;
  logic        terminal_write = 1'b0;
  logic [7:0]  terminal_data = '0;
  logic        vga_hsync, vga_vsync;
  logic [3:0]  vga_red, vga_green, vga_blue;

  always #5 clock = ~clock;

  vga_terminal #(.PIXEL_DIV(PD), .FG_COLOR(FG), .BG_COLOR(BG)) dut (
    .clock          (clock),
    .reset          (reset),
    .terminal_addr  (terminal_addr),
    .terminal_write (terminal_write),
    .terminal_data  (terminal_data),
    .vga_hsync      (vga_hsync),
    .vga_vsync      (vga_vsync),
    .vga_red        (vga_red),
    .vga_green      (vga_green),
    .vga_blue       (vga_blue)
  );

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [13:0] val;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] shadow [2400];
  logic [7:0] glyph_a [16] = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
                               8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] glyph_0 [16] = '{8'h00, 8'h00, 8'h7C, 8'hC6, 8'hC6, 8'hCE, 8'hDE, 8'hF6,
                               8'hE6, 8'hC6, 8'hC6, 8'h7C, 8'h00, 8'h00, 8'h00, 8'h00};

  int          checks = 0;
  int          failures = 0;
  int          bdiv = 0, bh = 0, bv = 0, rel_cyc = 0;
  int          hs_fall1 = -1, hs_rise1 = -1, hs_fall2 = -1;
  logic        prev_hs = 1'b1;
  logic [13:0] last_exp = IDLE;
  logic [9:0]  last_x = '0, last_y = '0;

  function automatic logic [13:0] exp_pixel(input int x, input int y);
    logic       hs, vs;
    logic [11:0] c;
    logic [7:0] ch, g;
    hs = !(x >= 656 && x < 752);
    vs = !(y >= 490 && y < 492);
    c  = 12'h000;
    if (x < 640 && y < 480) begin
      ch = shadow[(y / 16) * 80 + x / 8];
      g  = (ch == 8'h41) ? glyph_a[y % 16] : (ch == 8'h30) ? glyph_0[y % 16] : 8'h00;
      c  = g[7 - (x % 8)] ? FG : BG;
    end
    return {hs, vs, c};
  endfunction

  task automatic tick();
    logic        ce;
    logic [13:0] obs;
    exp_t        e;
    ce = !reset && (bdiv == PD - 1);
    if (ce) begin
      e.x = 10'(bh); e.y = 10'(bv); e.val = exp_pixel(bh, bv);
      sb.push_back(e);
    end
    @(posedge clock);
    if (terminal_write && terminal_addr < 12'd2400) shadow[terminal_addr] = terminal_data;
    if (reset) begin
      bdiv = 0; bh = 0; bv = 0; rel_cyc = 0;
      hs_fall1 = -1; hs_rise1 = -1; hs_fall2 = -1;
      sb.delete();
      e.x = '0; e.y = '0; e.val = IDLE;
      sb.push_back(e);
      sb.push_back(e);
      last_exp = IDLE;
    end else begin
      rel_cyc++;
      if (ce) begin
        bdiv = 0;
        if (bh == 799) begin
          bh = 0;
          bv = (bv == 524) ? 0 : bv + 1;
        end else begin
          bh++;
        end
        e = sb.pop_front();
        last_exp = e.val; last_x = e.x; last_y = e.y;
      end else begin
        bdiv++;
      end
    end
    #1;
    obs = {vga_hsync, vga_vsync, vga_red, vga_green, vga_blue};
    checks++;
    assert (obs === last_exp) else begin
      failures++;
      $error("FAIL pix x=%0d y=%0d observed=%h expected=%h", last_x, last_y, obs, last_exp);
    end
    if (!reset) begin
      if (prev_hs && !vga_hsync) begin
        if (hs_fall1 < 0) hs_fall1 = rel_cyc;
        else if (hs_fall2 < 0) hs_fall2 = rel_cyc;
      end
      if (!prev_hs && vga_hsync && hs_fall1 >= 0 && hs_rise1 < 0) hs_rise1 = rel_cyc;
    end
    prev_hs = vga_hsync;
  endtask

  task automatic wr(input logic [11:0] a, input logic [7:0] d);
    terminal_addr  = a;
    terminal_data  = d;
    terminal_write = 1'b1;
    tick();
    terminal_write = 1'b0;
  endtask

  task automatic wait_pixel(input int x, input int y);
    int n = 0;
    while (!(bh == x && bv == y && bdiv == PD - 1) && n < 60000) begin
      tick();
      n++;
    end
    checks++;
    assert (n < 60000) else begin
      failures++;
      $error("FAIL wait_pixel x=%0d y=%0d observed=timeout expected=reached", x, y);
    end
  endtask

  task automatic check_hsync();
    checks++;
    assert (hs_fall1 == 659 * PD) else begin
      failures++;
      $error("FAIL hs_first_fall observed=%0d expected=%0d", hs_fall1, 659 * PD);
    end
    checks++;
    assert (hs_rise1 == 755 * PD) else begin
      failures++;
      $error("FAIL hs_first_rise observed=%0d expected=%0d", hs_rise1, 755 * PD);
    end
    checks++;
    assert (hs_fall2 - hs_fall1 == 800 * PD) else begin
      failures++;
      $error("FAIL hs_period observed=%0d expected=%0d", hs_fall2 - hs_fall1, 800 * PD);
    end
  endtask

  initial begin
    // Buffer is cleared and preloaded while reset holds the scan idle.
    reset = 1'b1;
    tick();
    for (int i = 0; i < 2400; i++) wr(12'(i), 8'h00);
    wr(12'd0,    8'h41);
    wr(12'd2,    8'h30);
    wr(12'd5,    8'h80);
    wr(12'd6,    8'h1F);
    wr(12'd7,    8'hC1);
    wr(12'd8,    8'h20);
    wr(12'd79,   8'h30);
    wr(12'd81,   8'h30);
    wr(12'd2399, 8'h30);
    wr(12'd2400, 8'h31);
    wr(12'd4095, 8'h41);
    reset = 1'b0;

    // Overwrite cell 81 on the very edge that scans pixel (12,21).
    wait_pixel(12, 21);
    wr(12'd81, 8'h41);
    check_hsync();

    // Single-clock reset mid-frame, then the scan restarts from (0,0).
    wait_pixel(100, 33);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_pixel(0, 2);
    check_hsync();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
